// File: rtl/fp_alu_stream.sv
// Streaming FP ADD/SUB/MUL: latency L+1 (L = max wrapper depth), in order; output FIFO credit-guarded so out_ready stalls never drop work.
// Optional stat_ops/stat_stalls counters are built when FP_ALU_STREAM_STATS_EN is defined.

module fp_delay #(
  parameter int W = 1,
  parameter int N = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  if (N == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] pipe_q [N];
    logic [W-1:0] pipe_d [N];
    always_comb begin
      pipe_d[0] = din;
      for (int i = 1; i < N; i++) pipe_d[i] = pipe_q[i-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < N; i++) pipe_q[i] <= '0;
      else        pipe_q <= pipe_d;
    end
    assign dout = pipe_q[N-1];
  end
endmodule

module FP_Adder_Wrapper #(
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] x, y, sum;
  logic [7:0]  d;
  logic [24:0] mx, my, mag;
  logic [4:0]  sh;
  logic        found;
  int          e;

  // Truncating add; operands swapped so x carries the larger magnitude and the result sign.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d   = x[30:23] - y[30:23];
    mx  = {1'b0, |x[30:23], x[22:0]};
    my  = {1'b0, |y[30:23], y[22:0]};
    my  = (d > 8'd24) ? '0 : my >> d;
    mag = (x[31] == y[31]) ? mx + my : mx - my;
    e   = int'(x[30:23]);
    sh  = '0;
    found = 1'b0;
    if (mag[24]) begin
      mag = mag >> 1;
      e   = e + 1;
    end else begin
      for (int i = 23; i >= 0; i--)
        if (!found && mag[i]) begin sh = 5'(23 - i); found = 1'b1; end
      mag = mag << sh;
      e   = e - int'(sh);
    end
    if (mag == '0 || e <= 0) sum = '0;
    else if (e >= 255)       sum = {x[31], 8'hFF, 23'h0};
    else                     sum = {x[31], e[7:0], mag[22:0]};
  end

  fp_delay #(.W(32), .N(STAGES)) u_pipe (.clk(clk), .rst_n(~rst), .din(sum), .dout(result));
endmodule

module FP_Mult_Wrapper #(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);
  logic [47:0] ma, mb, prod;
  logic [22:0] frac;
  logic [31:0] res;
  logic        sgn, exc, ovf, unf;
  logic        unused_lo;
  int          e;

  always_comb begin
    sgn  = a[31] ^ b[31];
    ma   = {24'h0, |a[30:23], a[22:0]};
    mb   = {24'h0, |b[30:23], b[22:0]};
    prod = ma * mb;
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin frac = prod[46:24]; e = e + 1; end
    else frac = prod[45:23];
    res = '0;
    exc = 1'b0;
    ovf = 1'b0;
    unf = 1'b0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res = 32'h7FC0_0000;
      exc = 1'b1;
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      res = {sgn, 31'h0};
    end else if (e >= 255) begin
      res = {sgn, 8'hFF, 23'h0};
      exc = 1'b1;
      ovf = 1'b1;
    end else if (e <= 0) begin
      res = {sgn, 31'h0};
      exc = 1'b1;
      unf = 1'b1;
    end else begin
      res = {sgn, e[7:0], frac};
    end
  end
  assign unused_lo = ^prod[22:0];

  fp_delay #(.W(35), .N(STAGES)) u_pipe (
    .clk(clk), .rst_n(~rst), .din({exc, ovf, unf, res}),
    .dout({exception, overflow, underflow, result})
  );
endmodule

module fp_alu_stream #(
  parameter int ADDER_STAGES = 2,
  parameter int MULT_STAGES  = 3,
  parameter int TAG_W        = 4,
  parameter int FIFO_DEPTH   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exception,
  output logic             out_overflow,
  output logic             out_underflow
`ifdef FP_ALU_STREAM_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stalls
`endif
);
  localparam int L  = (ADDER_STAGES > MULT_STAGES) ? ADDER_STAGES : MULT_STAGES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } stg_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             exc;
    logic             ovf;
    logic             unf;
  } ent_t;

  logic          acc, dlv, push;
  logic [31:0]   b_eff, add_raw, add_al;
  logic [34:0]   mul_raw, mul_al;
  stg_t          stg_q [L];
  stg_t          stg_d [L];
  ent_t          push_ent, head;
  ent_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] occ_q, occ_d, cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  assign b_eff = (in_op == 2'b01) ? {~in_b[31], in_b[30:0]} : in_b;

  FP_Adder_Wrapper #(.STAGES(ADDER_STAGES)) u_add (
    .clk(clk), .rst(~reset_n), .a(in_a), .b(b_eff), .result(add_raw)
  );
  FP_Mult_Wrapper #(.STAGES(MULT_STAGES)) u_mul (
    .clk(clk), .rst(~reset_n), .a(in_a), .b(in_b), .result(mul_raw[31:0]),
    .exception(mul_raw[34]), .overflow(mul_raw[33]), .underflow(mul_raw[32])
  );

  // Pad the shorter unit so both results land at stage L with their request's valid/op/tag.
  fp_delay #(.W(32), .N(L - ADDER_STAGES)) u_add_al (.clk(clk), .rst_n(reset_n), .din(add_raw), .dout(add_al));
  fp_delay #(.W(35), .N(L - MULT_STAGES))  u_mul_al (.clk(clk), .rst_n(reset_n), .din(mul_raw), .dout(mul_al));

  assign acc = in_valid & rdy_q;
  assign out_valid = (occ_q != '0);
  assign dlv = out_valid & out_ready;
  assign push = stg_q[L-1].vld;
  assign in_ready = rdy_q;

  always_comb begin
    stg_d[0].vld = acc;
    stg_d[0].op  = in_op;
    stg_d[0].tag = in_tag;
    for (int i = 1; i < L; i++) stg_d[i] = stg_q[i-1];
  end

  always_comb begin
    push_ent = '0;
    push_ent.tag = stg_q[L-1].tag;
    case (stg_q[L-1].op)
      2'b00, 2'b01: push_ent.res = add_al;
      2'b10:        {push_ent.exc, push_ent.ovf, push_ent.unf, push_ent.res} = mul_al;
      default:      push_ent.exc = 1'b1;
    endcase
  end

  // cnt counts every accepted-but-undelivered request, so pipeline contents always have a FIFO slot.
  always_comb begin
    wr_d = wr_q;
    if (push) wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    rd_d = rd_q;
    if (dlv) rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    occ_d = occ_q;
    if (push && !dlv)      occ_d = occ_q + 1'b1;
    else if (!push && dlv) occ_d = occ_q - 1'b1;
    cnt_d = cnt_q;
    if (acc && !dlv)      cnt_d = cnt_q + 1'b1;
    else if (!acc && dlv) cnt_d = cnt_q - 1'b1;
    rdy_d = (cnt_d < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) stg_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_ent;
  end

  assign head          = mem_q[rd_q];
  assign out_result    = out_valid ? head.res : '0;
  assign out_tag       = out_valid ? head.tag : '0;
  assign out_exception = out_valid & head.exc;
  assign out_overflow  = out_valid & head.ovf;
  assign out_underflow = out_valid & head.unf;

`ifdef FP_ALU_STREAM_STATS_EN
  logic [31:0] ops_q, ops_d, stalls_q, stalls_d;

  always_comb begin
    ops_d    = ops_q + {31'h0, acc};
    stalls_d = stalls_q + {31'h0, in_valid & ~rdy_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_q    <= '0;
      stalls_q <= '0;
    end else begin
      ops_q    <= ops_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_ops    = ops_q;
  assign stat_stalls = stalls_q;
`endif
endmodule

// File: doc/fp_alu_stream.md
# fp_alu_stream

Latency-insensitive successor to the static floating-point ALU. It accepts ADD/SUB/MUL requests over a valid/ready handshake with a pass-through tag, and equalises adder and multiplier latency internally so results come back strictly in order. It buffers results in a credit-protected output FIFO so downstream back-pressure never corrupts in-flight work. It sits between an issue stage and any consumer that may stall, wrapping the existing `FP_Adder_Wrapper` / `FP_Mult_Wrapper` units, which have fixed latency and no stall input.

## Interface
Parameters:
- `ADDER_STAGES`, 2, adder wrapper latency in cycles (≥1).
- `MULT_STAGES`, 3, multiplier wrapper latency in cycles (≥1).
- `TAG_W`, 4, width of the request tag carried to the result (≥1).
- `FIFO_DEPTH`, 5, output FIFO entries. Must be ≥2; full throughput requires ≥ L+2, where L = max(ADDER_STAGES, MULT_STAGES).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request can be accepted.
- `in_a`, `in_b` input 32 each: IEEE-754 single-precision operands.
- `in_op` input 2: operation. 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- `in_tag` input TAG_W: opaque request tag.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output 32: result.
- `out_tag` output TAG_W: tag of the request that produced this result.
- `out_exception`, `out_overflow`, `out_underflow` output 1 each: result flags.

## Operation
- Accept: a request is accepted on a rising edge with `in_valid && in_ready`. Deliver: a result is delivered on a rising edge with `out_valid && out_ready`.
- SUB: `in_b` is passed to the adder with bit 31 inverted.
- Both wrappers are driven every cycle. Their reset inputs are tied to `~reset_n`, and correctness must not depend on their internal reset.
- Per-stage shift registers of depth L carry {valid, op, tag} alongside the wrappers.
- The adder result is delayed by L−ADDER_STAGES extra register stages, and the multiplier result by L−MULT_STAGES. Both are therefore aligned at stage L.
- Selection at stage L, only when the stage-L valid bit is set:
  - ADD/SUB: the aligned adder result, with all three flags 0.
  - MUL: the multiplier result and its exception/overflow/underflow.
  - Reserved op: result 32'h0, exception 1, overflow 0, underflow 0. The tag is still returned.
- The selected entry is pushed into the FIFO on the same edge.
- Credit counter `cnt` (0..FIFO_DEPTH):
  - +1 on accept, −1 on deliver, unchanged when both happen on the same edge.
  - `in_ready = (cnt < FIFO_DEPTH)`, driven from registers only, with no combinational path from `out_ready`.
  - A stage-L push therefore never finds the FIFO full.
- FIFO ordering and outputs:
  - First-in first-out, with wrap-around read/write pointers.
  - A simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged.
  - `out_valid` is high when the FIFO is non-empty.
  - When `out_valid` is 0, `out_result`, `out_tag` and all flags read 0 (gated).
- Results are strictly in acceptance order for any mix of operations.

## Timing
- Reset values (async assert):
  - `in_ready` = 1 after deassert. It is 0 while `reset_n` is low.
  - `out_valid` = 0. All data and flag outputs = 0.
  - `cnt` = 0. Pipelines and FIFO are empty.
- Reset mid-operation discards all in-flight and buffered results. There is no partial output after release.
- Latency: a request accepted in cycle t produces `out_valid` in cycle t+L+1 if the FIFO is empty and drained. ADD and MUL have identical latency.
- Throughput: one request per cycle when `out_ready` is held high and FIFO_DEPTH ≥ L+2.
- Back-pressure: with `out_ready` low, at most FIFO_DEPTH requests are accepted, then `in_ready` falls. `in_ready` rises in the cycle after the first delivery.
- Outputs are stable while `out_valid && !out_ready`.

## Configuration
- Macro: `FP_ALU_STREAM_STATS_EN`.
- Defined: adds ports `stat_ops` output 32 (accepted requests) and `stat_stalls` output 32 (cycles with `in_valid && !in_ready`). Both are wrapping counters, reset to 0 asynchronously.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- ADD 1.0 (3F800000) + 2.0 (40000000), tag 3, `out_ready` = 1 -> `out_valid` at t+4 (defaults, L=3), result 40400000, tag 3, flags 0.
- Back-to-back MUL 2.0×3.0 (tag 1), then ADD 1.0+1.0 (tag 2), then SUB 5.0−1.0 (tag 3) -> in-order results 40C00000/1, 40000000/2, 40800000/3 on consecutive cycles.
- Hold `out_ready` = 0 and drive `in_valid` for 8 cycles -> exactly 5 accepted, `in_ready` low from cycle 5. Release -> 5 results in order, no loss.
- MUL 7F000000 × 7F000000 -> `out_overflow` = 1. Reserved op with tag 9 -> result 0, exception 1, tag 9.
- Assert `reset_n` low with 3 requests in flight and 2 buffered -> `out_valid` = 0 immediately. After release, no stale result appears and `in_ready` = 1.
- With `FP_ALU_STREAM_STATS_EN`: saturate the FIFO as in scenario 3 -> `stat_ops` = 5 and `stat_stalls` = 3 after the 8 cycles.
